// File: rtl/conv3x3_sched.sv
// Window sequencer for the 3x3 conv MAC: walks every valid window per filter and
// tags each MAC result with its linear ofmap address after the fixed MAC latency.
module conv3x3_sched #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int NUM_CH  = 8,
  parameter int MAC_LAT = 3,
  parameter int OUT_AW  = 13,
  localparam int RW = $clog2(IMG_H),
  localparam int CW = $clog2(IMG_W),
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              win_ready,
  output logic              win_valid,
  output logic [RW-1:0]     win_row,
  output logic [CW-1:0]     win_col,
  output logic [SW-1:0]     wt_sel,
  output logic              res_valid,
  output logic [OUT_AW-1:0] res_addr,
  output logic              busy,
  output logic              done
);

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 3);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 3);
  localparam logic [SW-1:0] SEL_LAST = SW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_r;
  logic [RW-1:0]       row_r;
  logic [CW-1:0]       col_r;
  logic [SW-1:0]       sel_r;
  logic [OUT_AW-1:0]   issue_addr_r;
  logic                busy_r;
  logic                done_r;
  logic                sr_vld_r  [MAC_LAT];
  logic [OUT_AW-1:0]   sr_addr_r [MAC_LAT];
  logic                pipe_empty_s;

  assign win_valid = (state_r == S_RUN) && win_ready;
  assign win_row   = row_r;
  assign win_col   = col_r;
  assign wt_sel    = sel_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign res_valid = sr_vld_r[MAC_LAT-1];
  assign res_addr  = sr_addr_r[MAC_LAT-1];

  // The oldest stage retires this cycle, so only the younger stages keep the pass alive.
  always_comb begin
    pipe_empty_s = 1'b1;
    for (int i = 0; i < MAC_LAT - 1; i++) begin
      pipe_empty_s = pipe_empty_s & ~sr_vld_r[i];
    end
  end

  // Pass control and window counters: filter outermost, then row, then column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      row_r        <= '0;
      col_r        <= '0;
      sel_r        <= '0;
      issue_addr_r <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= S_RUN;
            busy_r  <= 1'b1;
          end
        end
        S_RUN: begin
          if (win_ready) begin
            issue_addr_r <= issue_addr_r + OUT_AW'(1);
            if (col_r == COL_LAST) begin
              col_r <= '0;
              if (row_r == ROW_LAST) begin
                row_r <= '0;
                if (sel_r == SEL_LAST) begin
                  sel_r        <= '0;
                  issue_addr_r <= '0;
                  state_r      <= S_DRAIN;
                end else begin
                  sel_r <= sel_r + SW'(1);
                end
              end else begin
                row_r <= row_r + RW'(1);
              end
            end else begin
              col_r <= col_r + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (pipe_empty_s) begin
            state_r <= S_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Valid/address delay line matching the MAC pipeline; it never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        sr_vld_r[i]  <= 1'b0;
        sr_addr_r[i] <= '0;
      end
    end else begin
      sr_vld_r[0]  <= win_valid;
      sr_addr_r[0] <= issue_addr_r;
      for (int i = 1; i < MAC_LAT; i++) begin
        sr_vld_r[i]  <= sr_vld_r[i-1];
        sr_addr_r[i] <= sr_addr_r[i-1];
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_sched.sv
// Bench for conv3x3_sched: three configurations checked every cycle against an
// issue-timestamp model, plus directed literal expectations from hand calculation.
module tb_conv3x3_sched;

  localparam int PH[3] = '{5, 28, 3};
  localparam int PW[3] = '{5, 28, 3};
  localparam int PC[3] = '{2, 8, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start_v = 3'b000;
  logic [2:0] rdy_v   = 3'b000;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic wv0, rv0, busy0, done0; logic [2:0] row0, col0; logic [0:0] sel0; logic [12:0] ra0;
  logic wv1, rv1, busy1, done1; logic [4:0] row1, col1; logic [2:0] sel1; logic [12:0] ra1;
  logic wv2, rv2, busy2, done2; logic [1:0] row2, col2; logic [0:0] sel2; logic [12:0] ra2;

  conv3x3_sched #(.IMG_W(5), .IMG_H(5), .NUM_CH(2), .MAC_LAT(3), .OUT_AW(13)) d0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .win_ready(rdy_v[0]), .win_valid(wv0),
    .win_row(row0), .win_col(col0), .wt_sel(sel0), .res_valid(rv0), .res_addr(ra0),
    .busy(busy0), .done(done0));
  conv3x3_sched #(.IMG_W(28), .IMG_H(28), .NUM_CH(8), .MAC_LAT(3), .OUT_AW(13)) d1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .win_ready(rdy_v[1]), .win_valid(wv1),
    .win_row(row1), .win_col(col1), .wt_sel(sel1), .res_valid(rv1), .res_addr(ra1),
    .busy(busy1), .done(done1));
  conv3x3_sched #(.IMG_W(3), .IMG_H(3), .NUM_CH(1), .MAC_LAT(3), .OUT_AW(13)) d2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .win_ready(rdy_v[2]), .win_valid(wv2),
    .win_row(row2), .win_col(col2), .wt_sel(sel2), .res_valid(rv2), .res_addr(ra2),
    .busy(busy2), .done(done2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // model state: phase 0 idle, 1 run, 2 drain, 3 done
  int m_ph[3];
  int m_k[3];
  int m_nr[3];
  int iss_cyc[3][5408];

  // observations pinned against hand-computed literals
  int mon_first_iss[3], mon_last_iss[3], mon_iss_cnt[3];
  int mon_first_res[3], mon_last_res[3], mon_res_cnt[3], mon_last_ra[3];
  int mon_done_cnt[3], mon_done_cyc[3];
  int snap675, snap676;

  task automatic chk(input string nm, input int id, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, id, cyc, act, exp);
    end
  endtask

  task automatic clr_mon(input int id);
    mon_first_iss[id] = -1; mon_last_iss[id] = -1; mon_iss_cnt[id] = 0;
    mon_first_res[id] = -1; mon_last_res[id] = -1; mon_res_cnt[id] = 0;
    mon_last_ra[id] = -1; mon_done_cnt[id] = 0; mon_done_cyc[id] = -1;
  endtask

  task automatic to_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare process: every DUT output checked against the model on every cycle.
  always @(negedge clk) begin
    for (int id = 0; id < 3; id++) begin
      int ow, orow, ocol, osel, orv, ora, obusy, odone;
      int hw, n, k, ewv, erv;
      case (id)
        0: begin ow = int'(wv0); orow = int'(row0); ocol = int'(col0); osel = int'(sel0);
                 orv = int'(rv0); ora = int'(ra0); obusy = int'(busy0); odone = int'(done0); end
        1: begin ow = int'(wv1); orow = int'(row1); ocol = int'(col1); osel = int'(sel1);
                 orv = int'(rv1); ora = int'(ra1); obusy = int'(busy1); odone = int'(done1); end
        default: begin ow = int'(wv2); orow = int'(row2); ocol = int'(col2); osel = int'(sel2);
                 orv = int'(rv2); ora = int'(ra2); obusy = int'(busy2); odone = int'(done2); end
      endcase
      hw = (PH[id] - 2) * (PW[id] - 2);
      n  = hw * PC[id];
      if (rst) begin
        chk("rst_win_valid", id, ow, 0);
        chk("rst_win_row", id, orow, 0);
        chk("rst_win_col", id, ocol, 0);
        chk("rst_wt_sel", id, osel, 0);
        chk("rst_res_valid", id, orv, 0);
        chk("rst_res_addr", id, ora, 0);
        chk("rst_busy", id, obusy, 0);
        chk("rst_done", id, odone, 0);
        m_ph[id] = 0; m_k[id] = 0; m_nr[id] = 0;
      end else begin
        k   = m_k[id];
        ewv = (m_ph[id] == 1 && rdy_v[id]) ? 1 : 0;
        chk("win_valid", id, ow, ewv);
        if (ewv == 1) begin
          chk("wt_sel", id, osel, k / hw);
          chk("win_row", id, orow, (k % hw) / (PW[id] - 2));
          chk("win_col", id, ocol, k % (PW[id] - 2));
        end
        erv = (m_nr[id] < m_k[id] && iss_cyc[id][m_nr[id]] == cyc - 3) ? 1 : 0;
        chk("res_valid", id, orv, erv);
        if (erv == 1) chk("res_addr", id, ora, m_nr[id]);
        chk("busy", id, obusy, (m_ph[id] == 1 || m_ph[id] == 2) ? 1 : 0);
        chk("done", id, odone, (m_ph[id] == 3) ? 1 : 0);
        if (ewv == 1) begin
          iss_cyc[id][k] = cyc;
          m_k[id] = k + 1;
        end
        if (erv == 1) m_nr[id] = m_nr[id] + 1;
        case (m_ph[id])
          0: if (start_v[id]) begin m_ph[id] = 1; m_k[id] = 0; m_nr[id] = 0; end
          1: if (m_k[id] == n) m_ph[id] = 2;
          2: if (m_nr[id] == n) m_ph[id] = 3;
          default: m_ph[id] = 0;
        endcase
        if (ow == 1) begin
          if (mon_first_iss[id] < 0) mon_first_iss[id] = cyc;
          mon_last_iss[id] = cyc;
          if (mon_iss_cnt[id] == 675) snap675 = osel * 1024 + orow * 32 + ocol;
          if (mon_iss_cnt[id] == 676) snap676 = osel * 1024 + orow * 32 + ocol;
          mon_iss_cnt[id]++;
        end
        if (orv == 1) begin
          if (mon_first_res[id] < 0) mon_first_res[id] = cyc;
          mon_last_res[id] = cyc;
          mon_last_ra[id] = ora;
          mon_res_cnt[id]++;
        end
        if (odone == 1) begin
          mon_done_cnt[id]++;
          mon_done_cyc[id] = cyc;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    for (int i = 0; i < 3; i++) clr_mon(i);
    to_cycle(3);
    rst = 1'b0;

    // Full-rate pass, 5x5x2, start in cycle 10
    clr_mon(0);
    rdy_v[0] = 1'b1;
    to_cycle(10); start_v[0] = 1'b1;
    to_cycle(11); start_v[0] = 1'b0;
    to_cycle(36);
    chk("t1_first_issue", 0, mon_first_iss[0], 11);
    chk("t1_last_issue", 0, mon_last_iss[0], 28);
    chk("t1_issue_count", 0, mon_iss_cnt[0], 18);
    chk("t1_first_res", 0, mon_first_res[0], 14);
    chk("t1_last_res", 0, mon_last_res[0], 31);
    chk("t1_last_addr", 0, mon_last_ra[0], 17);
    chk("t1_done_cycle", 0, mon_done_cyc[0], 32);
    chk("t1_done_count", 0, mon_done_cnt[0], 1);

    // win_ready toggling every cycle
    clr_mon(0);
    s = 40;
    to_cycle(s); start_v[0] = 1'b1; rdy_v[0] = 1'b1;
    for (int c = s + 1; c < s + 45; c++) begin
      to_cycle(c);
      start_v[0] = 1'b0;
      rdy_v[0] = ((c - s - 1) % 2 == 0) ? 1'b1 : 1'b0;
    end
    rdy_v[0] = 1'b1;
    to_cycle(s + 48);
    chk("t2_issue_count", 0, mon_iss_cnt[0], 18);
    chk("t2_issue_span", 0, mon_last_iss[0] - mon_first_iss[0], 34);
    chk("t2_res_count", 0, mon_res_cnt[0], 18);
    chk("t2_last_addr", 0, mon_last_ra[0], 17);
    chk("t2_done_after_last", 0, mon_done_cyc[0] - mon_last_iss[0], 4);
    chk("t2_done_count", 0, mon_done_cnt[0], 1);

    // start held through RUN, DRAIN and DONE is ignored
    clr_mon(0);
    s = 100;
    to_cycle(s); start_v[0] = 1'b1;
    to_cycle(s + 1); start_v[0] = 1'b0;
    to_cycle(s + 2); start_v[0] = 1'b1;
    to_cycle(s + 23); start_v[0] = 1'b0;
    to_cycle(s + 28);
    chk("t4_done_count", 0, mon_done_cnt[0], 1);
    chk("t4_done_cycle", 0, mon_done_cyc[0], s + 22);
    chk("t4_res_count", 0, mon_res_cnt[0], 18);
    start_v[0] = 1'b1;
    to_cycle(s + 29); start_v[0] = 1'b0;
    to_cycle(s + 55);
    chk("t4_second_done", 0, mon_done_cnt[0], 2);
    chk("t4_second_res", 0, mon_res_cnt[0], 36);

    // reset after seven issues
    s = 200;
    to_cycle(s); start_v[0] = 1'b1;
    to_cycle(s + 1); start_v[0] = 1'b0;
    clr_mon(0);
    to_cycle(s + 8);
    chk("t5_issues_before_rst", 0, mon_iss_cnt[0], 7);
    rst = 1'b1;
    to_cycle(s + 9); rst = 1'b0;
    clr_mon(0);
    to_cycle(s + 15);
    chk("t5_quiet_res", 0, mon_res_cnt[0], 0);
    chk("t5_quiet_issue", 0, mon_iss_cnt[0], 0);
    start_v[0] = 1'b1;
    to_cycle(s + 16); start_v[0] = 1'b0;
    to_cycle(s + 42);
    chk("t5_res_count", 0, mon_res_cnt[0], 18);
    chk("t5_last_addr", 0, mon_last_ra[0], 17);
    chk("t5_done_count", 0, mon_done_cnt[0], 1);

    // minimum configuration 3x3x1
    clr_mon(2);
    rdy_v[2] = 1'b1;
    s = 260;
    to_cycle(s); start_v[2] = 1'b1;
    to_cycle(s + 1); start_v[2] = 1'b0;
    to_cycle(s + 9);
    chk("t6_issue_cycle", 2, mon_first_iss[2], s + 1);
    chk("t6_issue_count", 2, mon_iss_cnt[2], 1);
    chk("t6_res_cycle", 2, mon_first_res[2], s + 4);
    chk("t6_res_addr", 2, mon_last_ra[2], 0);
    chk("t6_done_cycle", 2, mon_done_cyc[2], s + 5);

    // full-size 28x28x8 wrap check
    clr_mon(1);
    rdy_v[1] = 1'b1;
    s = 300;
    to_cycle(s); start_v[1] = 1'b1;
    to_cycle(s + 1); start_v[1] = 1'b0;
    to_cycle(s + 5408 + 10);
    chk("t3_issue_count", 1, mon_iss_cnt[1], 5408);
    chk("t3_win675", 1, snap675, 825);
    chk("t3_win676", 1, snap676, 1024);
    chk("t3_last_addr", 1, mon_last_ra[1], 5407);
    chk("t3_done_cycle", 1, mon_done_cyc[1], s + 5408 + 4);
    chk("t3_done_count", 1, mon_done_cnt[1], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
